// File: rtl/tfifo_cfg.sv
// Elastic circular-buffer FIFO with a compile-time output mode: transparent
// (bypass when empty) or registered. It also exports registered occupancy and almost-full.
module tfifo_cfg #(
  parameter int SLOTS       = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int TRANSPARENT = 1,
  parameter int AF_THRESH   = SLOTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready,
  output logic [$clog2(SLOTS+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(SLOTS + 1);
  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SLOTS);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(SLOTS - 1);

  logic [DATA_WIDTH-1:0] mem_q [SLOTS];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  af_q, af_d;
  logic                  empty, full, enq, deq;

  // Valid/ready: a word moves on a rising edge only when valid && ready on that
  // channel; a producer holding valid=1 keeps its payload stable until accepted.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_CNT);
    outs_valid = !empty;
    outs       = mem_q[head_q];
    ins_ready  = !full;
    enq        = ins_valid && !full;
    if (TRANSPARENT != 0) begin
      outs_valid = ins_valid || !empty;
      outs       = empty ? ins : mem_q[head_q];
      ins_ready  = !full || outs_ready;
      // When empty and the consumer takes the word, it bypasses storage entirely.
      enq        = ins_valid && ins_ready && !(empty && outs_ready);
    end
    deq = !empty && outs_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
    if (enq) tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CW'(1);
    end
    af_d = (count_d >= AF_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      af_q    <= af_d;
    end
  end

  // Payload storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= ins;
  end

  assign count       = count_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_tfifo_cfg.sv
// Bench for tfifo_cfg: directed vector table over several configurations, then
// randomized valid/ready traffic checked against a queue scoreboard every cycle.
`timescale 1ns/1ps
module tb_tfifo_cfg;

  localparam int NI = 8;
  localparam int P_S  [NI] = '{2, 4, 3, 1, 1, 3, 8, 8};
  localparam int P_T  [NI] = '{1, 0, 0, 1, 0, 1, 1, 0};
  localparam int P_AF [NI] = '{2, 4, 2, 1, 1, 3, 5, 8};

  logic       clk;
  logic       rst;
  logic [7:0] ins_a  [NI];
  logic       iv_a   [NI];
  logic       ir_a   [NI];
  logic [7:0] outs_a [NI];
  logic       ov_a   [NI];
  logic       ordy_a [NI];
  logic [3:0] cnt_a  [NI];
  logic       af_a   [NI];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = P_S[g];
    logic [$clog2(S+1)-1:0] cnt;
    tfifo_cfg #(
      .SLOTS(S), .DATA_WIDTH(8), .TRANSPARENT(P_T[g]), .AF_THRESH(P_AF[g])
    ) u_dut (
      .clk(clk), .rst(rst),
      .ins(ins_a[g]), .ins_valid(iv_a[g]), .ins_ready(ir_a[g]),
      .outs(outs_a[g]), .outs_valid(ov_a[g]), .outs_ready(ordy_a[g]),
      .count(cnt), .almost_full(af_a[g])
    );
    assign cnt_a[g] = 4'(cnt);
  end

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         inst;
    logic       rst;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       e_ov;
    logic       c_outs;
    logic [7:0] e_outs;
    logic       e_ir;
    logic [3:0] e_cnt;
    logic       e_af;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input int inst, input int r, input int iv, input int din,
                            input int ordy, input int ov, input int co, input int eo,
                            input int ir, input int cnt, input int af);
    vec_t x;
    x.inst = inst;       x.rst = 1'(r);     x.iv = 1'(iv);     x.din = 8'(din);
    x.ordy = 1'(ordy);   x.e_ov = 1'(ov);   x.c_outs = 1'(co); x.e_outs = 8'(eo);
    x.e_ir = 1'(ir);     x.e_cnt = 4'(cnt); x.e_af = 1'(af);
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input int inst, input logic iv, input logic [7:0] d, input logic ordy);
    for (int i = 0; i < NI; i++) begin
      iv_a[i]   = 1'b0;
      ordy_a[i] = 1'b0;
      ins_a[i]  = 8'h00;
    end
    iv_a[inst]   = iv;
    ins_a[inst]  = d;
    ordy_a[inst] = ordy;
  endtask

  task automatic do_reset(input int inst);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(inst, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.ov",  inst, 32'(ov_a[inst]),  32'd0);
    check("rst.ir",  inst, 32'(ir_a[inst]),  32'd1);
    check("rst.cnt", inst, 32'(cnt_a[inst]), 32'd0);
    check("rst.af",  inst, 32'(af_a[inst]),  32'd0);
  endtask

  task automatic run_vectors();
    int cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].inst != cur) begin
        cur = vecs[i].inst;
        do_reset(cur);
      end
      @(posedge clk); #1;
      rst = vecs[i].rst;
      drive(cur, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      @(negedge clk);
      check("vec.ov",  i, 32'(ov_a[cur]),  32'(vecs[i].e_ov));
      check("vec.ir",  i, 32'(ir_a[cur]),  32'(vecs[i].e_ir));
      check("vec.cnt", i, 32'(cnt_a[cur]), 32'(vecs[i].e_cnt));
      check("vec.af",  i, 32'(af_a[cur]),  32'(vecs[i].e_af));
      if (vecs[i].c_outs) check("vec.outs", i, 32'(outs_a[cur]), 32'(vecs[i].e_outs));
    end
  endtask

  // Scoreboard: exp_q holds the words the FIFO should currently store.
  task automatic run_rand(input int inst, input int ncyc);
    int s, af, m;
    bit t;
    logic riv, rrdy, e_ov, e_ir, out_x, in_x;
    logic [7:0] rd;
    s  = P_S[inst];
    t  = (P_T[inst] != 0);
    af = P_AF[inst];
    do_reset(inst);
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      riv  = 1'($urandom_range(0, 1));
      rrdy = 1'($urandom_range(0, 1));
      rd   = 8'($urandom_range(0, 255));
      drive(inst, riv, rd, rrdy);
      @(negedge clk);
      m    = exp_q.size();
      e_ov = t ? (riv || m > 0) : (m > 0);
      e_ir = t ? (m < s || rrdy) : (m < s);
      check("rnd.ov",  inst, 32'(ov_a[inst]),  32'(e_ov));
      check("rnd.ir",  inst, 32'(ir_a[inst]),  32'(e_ir));
      check("rnd.cnt", inst, 32'(cnt_a[inst]), 32'(m));
      check("rnd.af",  inst, 32'(af_a[inst]),  32'(m >= af));
      if (e_ov) check("rnd.outs", inst, 32'(outs_a[inst]), 32'((m > 0) ? exp_q[0] : rd));
      out_x = e_ov && rrdy;
      in_x  = riv && e_ir;
      if (out_x && m > 0) void'(exp_q.pop_front());
      if (in_x && !(m == 0 && out_x)) exp_q.push_back(rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);

    // inst, rst, iv, din, ordy | ov, chk_outs, outs, ir, cnt, af
    // transparent, SLOTS=2: bypass stream, fill, full enq+deq, mid-stream reset
    v(0,0,1,'h01,1, 1,1,'h01, 1,0,0);
    v(0,0,1,'h02,1, 1,1,'h02, 1,0,0);
    v(0,0,1,'h03,1, 1,1,'h03, 1,0,0);
    v(0,0,1,'h0A,0, 1,1,'h0A, 1,0,0);
    v(0,0,1,'h0B,0, 1,1,'h0A, 1,1,0);
    v(0,0,1,'h0C,0, 1,1,'h0A, 0,2,1);
    v(0,0,1,'h0C,1, 1,1,'h0A, 1,2,1);
    v(0,0,0,'h00,1, 1,1,'h0B, 1,2,1);
    v(0,0,0,'h00,1, 1,1,'h0C, 1,1,0);
    v(0,0,0,'h00,1, 0,0,'h00, 1,0,0);
    v(0,0,1,'h21,0, 1,1,'h21, 1,0,0);
    v(0,0,1,'h22,0, 1,1,'h21, 1,1,0);
    v(0,1,1,'h23,0, 1,1,'h21, 0,2,1);
    v(0,0,1,'h33,1, 1,1,'h33, 1,0,0);
    v(0,0,0,'h00,0, 0,0,'h00, 1,0,0);
    // registered, SLOTS=4: one-cycle latency, 1/cycle stream, mid-stream reset
    v(1,0,1,'h10,1, 0,0,'h00, 1,0,0);
    v(1,0,1,'h11,1, 1,1,'h10, 1,1,0);
    v(1,0,1,'h12,1, 1,1,'h11, 1,1,0);
    v(1,0,1,'h13,1, 1,1,'h12, 1,1,0);
    v(1,0,0,'h00,1, 1,1,'h13, 1,1,0);
    v(1,0,0,'h00,1, 0,0,'h00, 1,0,0);
    v(1,0,1,'h40,0, 0,0,'h00, 1,0,0);
    v(1,0,1,'h41,0, 1,1,'h40, 1,1,0);
    v(1,1,1,'h42,0, 1,1,'h40, 1,2,0);
    v(1,0,1,'h43,1, 0,0,'h00, 1,0,0);
    v(1,0,0,'h00,1, 1,1,'h43, 1,1,0);
    v(1,0,0,'h00,1, 0,0,'h00, 1,0,0);
    // registered, SLOTS=3, AF_THRESH=2: fill past full, then drain across pointer wrap
    v(2,0,1,'h01,0, 0,0,'h00, 1,0,0);
    v(2,0,1,'h02,0, 1,1,'h01, 1,1,0);
    v(2,0,1,'h03,0, 1,1,'h01, 1,2,1);
    v(2,0,1,'h04,0, 1,1,'h01, 0,3,1);
    v(2,0,1,'h05,0, 1,1,'h01, 0,3,1);
    v(2,0,0,'h00,1, 1,1,'h01, 0,3,1);
    v(2,0,1,'h04,1, 1,1,'h02, 1,2,1);
    v(2,0,1,'h05,1, 1,1,'h03, 1,2,1);
    v(2,0,0,'h00,1, 1,1,'h04, 1,2,1);
    v(2,0,0,'h00,1, 1,1,'h05, 1,1,0);
    v(2,0,0,'h00,1, 0,0,'h00, 1,0,0);
    // transparent, SLOTS=1: full with simultaneous enq and deq
    v(3,0,1,'h51,0, 1,1,'h51, 1,0,0);
    v(3,0,1,'h52,1, 1,1,'h51, 1,1,1);
    v(3,0,1,'h53,1, 1,1,'h52, 1,1,1);
    v(3,0,0,'h00,1, 1,1,'h53, 1,1,1);
    v(3,0,0,'h00,0, 0,0,'h00, 1,0,0);
    // registered, SLOTS=1: one transfer every two cycles
    v(4,0,1,'hAA,1, 0,0,'h00, 1,0,0);
    v(4,0,1,'hBB,1, 1,1,'hAA, 0,1,1);
    v(4,0,1,'hBB,1, 0,0,'h00, 1,0,0);
    v(4,0,0,'h00,1, 1,1,'hBB, 0,1,1);
    v(4,0,0,'h00,1, 0,0,'h00, 1,0,0);

    run_vectors();

    for (int i = 2; i < NI; i++) run_rand(i, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
